// File: rtl/led_sweep_gen_pkg.sv
// Shared types and constants for the LED sweep generator.
//   sweep_state_t : FSM state encoding (IDLE, SWEEP, HOLD)
//   LED_HOME      : pattern shown at reset and on every return to SWEEP
//   FLASH_HIT     : flash pattern after a HIT
//   FLASH_MISS    : flash pattern after a MISS
//   rotate_right  : one LED step toward the LSB, wrapping bit 0 back to bit 7
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      HOLD  = 2'd2
   } sweep_state_t;

   localparam logic [7:0] LED_HOME   = 8'b1000_0000;
   localparam logic [7:0] FLASH_HIT  = 8'hFF;
   localparam logic [7:0] FLASH_MISS = 8'h81;

   function automatic logic [7:0] rotate_right(input logic [7:0] v);
      return {v[0], v[7:1]};
   endfunction

endpackage

// File: rtl/led_sweep_gen_if.sv
// Control/status bundle of the LED sweep generator.
//   en    : run enable (0 = pause everything)
//   hit   : 1-cycle detector pulse, press on target
//   miss  : 1-cycle detector pulse, press off target
//   leds  : one-hot sweep / flash pattern
//   pos   : index of the lit LED (7 = MSB)
//   step  : 1-cycle pulse on the cycle leds advances
//   level : current speed level
//   busy  : 1 while the result is being flashed
// master = the side driving en/hit/miss, slave = the generator.
interface led_sweep_gen_if;
   logic       en;
   logic       hit;
   logic       miss;
   logic [7:0] leds;
   logic [2:0] pos;
   logic       step;
   logic [3:0] level;
   logic       busy;

   modport master (
      output en, hit, miss,
      input  leds, pos, step, level, busy
   );

   modport slave (
      input  en, hit, miss,
      output leds, pos, step, level, busy
   );
endinterface

// File: rtl/led_sweep_gen_prescaler.sv
// Step-rate prescaler: counts 0..period-1 while enabled and flags the last
// count as a tick; the counter wraps to 0 on the following cycle.
//   clk, rst : clock, asynchronous active-high reset
//   period   : step period in clock cycles (wider than the counter so the
//              caller can hand over its saturated arithmetic directly)
//   en       : count enable
//   clr      : synchronous clear to 0, wins over en
//   tick     : high on the cycle where cnt == period-1 and en is set
module sweep_prescaler #(
   parameter int DIV_W    = 27,
   parameter int PERIOD_W = DIV_W + 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PERIOD_W-1:0] period,
   input  logic                en,
   input  logic                clr,
   output logic                tick
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic             last_s;

   // Terminal-count detect and next counter value.
   // ">=" keeps the counter from running away if period ever drops below cnt.
   always_comb begin
      last_s = ({{(PERIOD_W-DIV_W){1'b0}}, cnt_q} >= (period - PERIOD_W'(1)));
      cnt_d  = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (last_s) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign tick = en & last_s;

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_sweep_gen.sv
// One-hot LED sweep for the precision-button game. The lit LED walks from
// bit 7 toward bit 0 at a prescaled rate and wraps. HIT raises the speed
// level (saturating), MISS drops it to 0; either result freezes the sweep
// and flashes a pattern for HOLD_STEPS step periods before resuming at bit 7.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of led_sweep_gen_if (en/hit/miss in,
//              leds/pos/step/level/busy out, all outputs registered)
module led_sweep_gen
   import sweep_pkg::*;
#(
   parameter int DIV_W      = 27,
   parameter int BASE_DIV   = 50_000_000,
   parameter int STEP_DIV   = 5_000_000,
   parameter int MIN_DIV    = 5_000_000,
   parameter int MAX_LEVEL  = 7,
   parameter int HOLD_STEPS = 4
) (
   input  logic           clk,
   input  logic           rst,
   led_sweep_gen_if.slave bus
);

   localparam int PW   = DIV_W + 4;
   localparam int HC_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

   sweep_state_t    state_q,    state_d;
   logic [7:0]      leds_q,     leds_d;
   logic [2:0]      pos_q,      pos_d;
   logic            step_q,     step_d;
   logic [3:0]      level_q,    level_d;
   logic            busy_q,     busy_d;
   logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
   logic            miss_res_q, miss_res_d;   // 1: flashing a MISS result

   logic [PW-1:0]   dec_s;
   logic [PW-1:0]   period_s;
   logic [7:0]      flash_pat_s;
   logic            run_s;
   logic            clr_s;
   logic            tick_s;

   // Step period for the current level, floored at MIN_DIV without underflow.
   always_comb begin
      dec_s = PW'(level_q) * PW'(STEP_DIV);
      if (dec_s >= PW'(BASE_DIV)) begin
         period_s = PW'(MIN_DIV);
      end else if ((PW'(BASE_DIV) - dec_s) < PW'(MIN_DIV)) begin
         period_s = PW'(MIN_DIV);
      end else begin
         period_s = PW'(BASE_DIV) - dec_s;
      end
   end

   sweep_prescaler #(
      .DIV_W    (DIV_W),
      .PERIOD_W (PW)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .period (period_s),
      .en     (run_s),
      .clr    (clr_s),
      .tick   (tick_s)
   );

   // FSM, LED shifter, level and hold counter next-state logic.
   always_comb begin
      state_d     = state_q;
      leds_d      = leds_q;
      pos_d       = pos_q;
      step_d      = 1'b0;
      level_d     = level_q;
      busy_d      = busy_q;
      hold_cnt_d  = hold_cnt_q;
      miss_res_d  = miss_res_q;
      clr_s       = 1'b0;
      run_s       = bus.en && ((state_q == SWEEP) || (state_q == HOLD));
      flash_pat_s = miss_res_q ? FLASH_MISS : FLASH_HIT;

      case (state_q)
         IDLE: begin
            if (bus.en) begin
               state_d = SWEEP;
               leds_d  = LED_HOME;
               pos_d   = 3'd7;
               clr_s   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end

         SWEEP: begin
            if (!bus.en) begin
               state_d = SWEEP;
            end else if (bus.miss) begin
               // MISS has priority over a simultaneous HIT and over a tick.
               state_d    = HOLD;
               level_d    = 4'd0;
               busy_d     = 1'b1;
               hold_cnt_d = '0;
               miss_res_d = 1'b1;
               leds_d     = FLASH_MISS;
               clr_s      = 1'b1;
            end else if (bus.hit) begin
               state_d    = HOLD;
               level_d    = (level_q >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : (level_q + 4'd1);
               busy_d     = 1'b1;
               hold_cnt_d = '0;
               miss_res_d = 1'b0;
               leds_d     = FLASH_HIT;
               clr_s      = 1'b1;
            end else if (tick_s) begin
               leds_d = rotate_right(leds_q);
               pos_d  = pos_q - 3'd1;
               step_d = 1'b1;
            end else begin
               leds_d = leds_q;
            end
         end

         HOLD: begin
            if (!tick_s) begin
               state_d = HOLD;
            end else if (hold_cnt_q == HC_W'(HOLD_STEPS - 1)) begin
               state_d    = SWEEP;
               leds_d     = LED_HOME;
               pos_d      = 3'd7;
               busy_d     = 1'b0;
               hold_cnt_d = '0;
               clr_s      = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HC_W'(1);
               leds_d     = (leds_q == 8'h00) ? flash_pat_s : 8'h00;
            end
         end

         default: begin
            state_d    = IDLE;
            leds_d     = LED_HOME;
            pos_d      = 3'd7;
            level_d    = 4'd0;
            busy_d     = 1'b0;
            hold_cnt_d = '0;
            miss_res_d = 1'b0;
            clr_s      = 1'b1;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         leds_q     <= LED_HOME;
         pos_q      <= 3'd7;
         step_q     <= 1'b0;
         level_q    <= 4'd0;
         busy_q     <= 1'b0;
         hold_cnt_q <= '0;
         miss_res_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         leds_q     <= leds_d;
         pos_q      <= pos_d;
         step_q     <= step_d;
         level_q    <= level_d;
         busy_q     <= busy_d;
         hold_cnt_q <= hold_cnt_d;
         miss_res_q <= miss_res_d;
      end
   end

   assign bus.leds  = leds_q;
   assign bus.pos   = pos_q;
   assign bus.step  = step_q;
   assign bus.level = level_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_sweep_gen.sv
// Directed bench for led_sweep_gen with a step scoreboard: expected step
// records (leds, pos, level, cycles since previous step) are queued when the
// stimulus is issued and compared whenever the DUT pulses STEP.
module tb_led_sweep_gen;

   localparam int T_BASE = 4;
   localparam int T_STEP = 1;
   localparam int T_MIN  = 2;
   localparam int T_MAX  = 3;
   localparam int T_HOLD = 2;

   logic clk = 1'b0;
   logic rst;

   led_sweep_gen_if bus ();

   led_sweep_gen #(
      .DIV_W      (27),
      .BASE_DIV   (T_BASE),
      .STEP_DIV   (T_STEP),
      .MIN_DIV    (T_MIN),
      .MAX_LEVEL  (T_MAX),
      .HOLD_STEPS (T_HOLD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] leds;
      logic [2:0] pos;
      logic [3:0] level;
      int         gap;
   } step_rec_t;

   step_rec_t sb[$];
   int        errors  = 0;
   int        checks  = 0;
   int        gap_cnt = 0;
   logic      en_at_edge = 1'b0;
   logic      busy_prev  = 1'b0;
   int        exp_pos = 7;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_period(input int lvl);
      int p;
      p = T_BASE - lvl * T_STEP;
      if (p < T_MIN) p = T_MIN;
      return p;
   endfunction

   // Queue n sweep steps continuing from the current expected position.
   task automatic push_steps(input int n, input int lvl, input int first_gap);
      for (int i = 0; i < n; i++) begin
         step_rec_t r;
         exp_pos = (exp_pos + 7) % 8;
         r.leds  = 8'd1 << exp_pos;
         r.pos   = 3'(exp_pos);
         r.level = 4'(lvl);
         r.gap   = (i == 0 && first_gap > 0) ? first_gap : exp_period(lvl);
         sb.push_back(r);
      end
   endtask

   // Wait (bounded) until every queued step has been seen; ends at negedge+1.
   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_drain"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic check_outs(input string tag, input logic [7:0] l, input logic [2:0] p,
                             input logic [3:0] lv, input logic b);
      check({tag, "_leds"},  32'(bus.leds),  32'(l));
      check({tag, "_pos"},   32'(bus.pos),   32'(p));
      check({tag, "_level"}, 32'(bus.level), 32'(lv));
      check({tag, "_busy"},  32'(bus.busy),  32'(b));
      check({tag, "_step"},  32'(bus.step),  32'd0);
   endtask

   // Issue a result (after pre extra edges), then follow the whole flash and
   // the return to LED_HOME. Called at negedge+1 of a step cycle (cnt == 0).
   task automatic result_hold(input string tag, input logic h, input logic m, input int pre,
                              input int lvl, input logic [7:0] pat);
      int p;
      repeat (pre) @(posedge clk);
      if (pre > 0) #1;
      bus.hit  = h;
      bus.miss = m;
      @(posedge clk);
      #1;
      bus.hit  = 1'b0;
      bus.miss = 1'b0;
      p = exp_period(lvl);
      @(negedge clk);
      check({tag, "_level"}, 32'(bus.level), 32'(lvl));
      check({tag, "_busy"},  32'(bus.busy),  32'd1);
      check({tag, "_flash0"}, 32'(bus.leds), 32'(pat));
      for (int i = 1; i < T_HOLD * p; i++) begin
         @(negedge clk);
         check({tag, "_flash"}, 32'(bus.leds), ((i / p) % 2 == 0) ? 32'(pat) : 32'd0);
         check({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
      end
      @(negedge clk);
      check_outs({tag, "_resume"}, 8'h80, 3'd7, 4'(lvl), 1'b0);
      exp_pos = 7;
   endtask

   // Enable seen by the DUT at each rising edge.
   always @(posedge clk) en_at_edge <= bus.en && !rst;

   // Step monitor: pops and compares one scoreboard record per STEP pulse.
   always @(negedge clk) begin
      if (rst) begin
         gap_cnt   <= 0;
         busy_prev <= 1'b0;
      end else begin
         busy_prev <= bus.busy;
         if (bus.step === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_step", 32'(bus.step), 32'd0);
            end else begin
               check("step_leds",  32'(bus.leds),  32'(sb[0].leds));
               check("step_pos",   32'(bus.pos),   32'(sb[0].pos));
               check("step_level", 32'(bus.level), 32'(sb[0].level));
               check("step_gap",   32'(gap_cnt + (en_at_edge ? 1 : 0)), 32'(sb[0].gap));
               sb.delete(0);
            end
            gap_cnt <= 0;
         end else if (busy_prev === 1'b1 && bus.busy === 1'b0) begin
            gap_cnt <= 0;
         end else begin
            gap_cnt <= gap_cnt + (en_at_edge ? 1 : 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst      = 1'b1;
      bus.en   = 1'b0;
      bus.hit  = 1'b0;
      bus.miss = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outs("reset", 8'h80, 3'd7, 4'd0, 1'b0);

      // 1: free sweep at level 0, one full wrap (first step includes IDLE cycle)
      @(posedge clk);
      #1;
      rst    = 1'b0;
      bus.en = 1'b1;
      exp_pos = 7;
      push_steps(8, 0, T_BASE + 1);
      wait_drain("wrap", 80);

      // 2: HIT with LEDS = 0x10
      push_steps(3, 0, 0);
      wait_drain("to_10", 40);
      check("at_10_leds", 32'(bus.leds), 32'h10);
      result_hold("hit1", 1'b1, 1'b0, 0, 1, 8'hFF);
      push_steps(2, 1, 0);
      wait_drain("lvl1", 30);

      // 3: further HITs up to and past saturation
      result_hold("hit2", 1'b1, 1'b0, 0, 2, 8'hFF);
      push_steps(2, 2, 0);
      wait_drain("lvl2", 30);
      result_hold("hit3", 1'b1, 1'b0, 0, 3, 8'hFF);
      push_steps(2, 3, 0);
      wait_drain("lvl3", 30);
      result_hold("hit4_sat", 1'b1, 1'b0, 0, 3, 8'hFF);
      push_steps(2, 3, 0);
      wait_drain("lvl3b", 30);

      // 4: HIT+MISS together, then MISS at level 2
      result_hold("hitmiss", 1'b1, 1'b1, 0, 0, 8'h81);
      push_steps(1, 0, 0);
      wait_drain("after_hm", 30);
      result_hold("hit5", 1'b1, 1'b0, 0, 1, 8'hFF);
      push_steps(1, 1, 0);
      wait_drain("lvl1c", 30);
      result_hold("hit6", 1'b1, 1'b0, 0, 2, 8'hFF);
      push_steps(1, 2, 0);
      wait_drain("lvl2c", 30);
      result_hold("miss", 1'b0, 1'b1, 0, 0, 8'h81);
      push_steps(3, 0, 0);
      wait_drain("after_miss", 40);

      // HIT on the same edge as a tick: the step must not happen
      result_hold("hit_on_tick", 1'b1, 1'b0, exp_period(0) - 1, 1, 8'hFF);
      push_steps(2, 1, 0);
      wait_drain("after_hot", 30);

      // 5a: pause mid-sweep with a HIT during the pause
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         check_outs("pause_sweep", 8'd1 << exp_pos, 3'(exp_pos), 4'd1, 1'b0);
         #1;
         bus.hit = (i == 3);
      end
      bus.hit = 1'b0;
      bus.en  = 1'b1;
      push_steps(1, 1, 0);
      wait_drain("pause_sweep_resume", 20);

      // 5b: pause mid-HOLD
      bus.hit = 1'b1;
      @(posedge clk);
      #1;
      bus.hit = 1'b0;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_outs("pause_hold", 8'hFF, 3'(exp_pos), 4'd2, 1'b1);
         #1;
         bus.miss = (i == 4);
      end
      bus.miss = 1'b0;
      bus.en   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy === 1'b1 && n < 20);
      check("pause_hold_remaining", 32'(n), 32'(T_HOLD * exp_period(2) - 1));
      check_outs("pause_hold_exit", 8'h80, 3'd7, 4'd2, 1'b0);
      exp_pos = 7;
      #1;
      push_steps(1, 2, 0);
      wait_drain("after_pause_hold", 20);

      // 6: asynchronous reset between edges in the middle of HOLD
      bus.hit = 1'b1;
      @(posedge clk);
      #1;
      bus.hit = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_outs("async_rst", 8'h80, 3'd7, 4'd0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_pos = 7;
      push_steps(2, 0, T_BASE + 1);
      wait_drain("after_rst", 30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
